// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 4;

    // Bit-counter width: must hold WIDTH+1 when the parity bit is appended.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter of bits remaining in the frame; decodes busy and last.
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy,
    output logic          last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);
    assign last = (cnt == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// PISO shift register, MSB first by default; defining PISO_PARITY_EN appends
// an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel,
    input  logic             load,
    output logic             serial,
    output logic             busy,
    output logic             last
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH);
`endif

    // load is a one-cycle strobe with priority: it restarts the frame on any edge.
    logic [WIDTH-1:0] sreg;
    logic             out_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= parallel;
        end else if (busy) begin
            // Zero fill keeps serial low once all data bits have left.
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end
    end

    piso_bit_counter #(
        .CW(CW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(FRAME_LEN),
        .busy    (busy),
        .last    (last)
    );

    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

`ifdef PISO_PARITY_EN
    logic parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^parallel;
        end
    end

    // By the final cycle the data bits have all shifted out, so parity takes the line.
    assign serial = last ? parity : out_bit;
`else
    assign serial = out_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer: MSB-first and LSB-first instances
// against a queue-of-bits reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] parallel = '0;
    logic         load = 1'b0;
    logic         serial_m, busy_m, last_m;
    logic         serial_l, busy_l, last_l;

    int total = 0;
    int bad   = 0;

    bit exp_m[$];
    bit exp_l[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .parallel(parallel), .load(load),
        .serial(serial_m), .busy(busy_m), .last(last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .parallel(parallel), .load(load),
        .serial(serial_l), .busy(busy_l), .last(last_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // The frame is simply the list of bits in transmit order.
    task automatic model_load(input logic [W-1:0] word);
        exp_m.delete();
        exp_l.delete();
        for (int i = 0; i < W; i++) begin
            exp_m.push_back(word[W-1-i]);
            exp_l.push_back(word[i]);
        end
`ifdef PISO_PARITY_EN
        exp_m.push_back(^word);
        exp_l.push_back(^word);
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".serial_msb"}, serial_m, exp_m.size() != 0 ? exp_m[0] : 1'b0);
        check({tag, ".busy_msb"}, busy_m, exp_m.size() != 0);
        check({tag, ".last_msb"}, last_m, exp_m.size() == 1);
        check({tag, ".serial_lsb"}, serial_l, exp_l.size() != 0 ? exp_l[0] : 1'b0);
        check({tag, ".busy_lsb"}, busy_l, exp_l.size() != 0);
        check({tag, ".last_lsb"}, last_l, exp_l.size() == 1);
    endtask

    // Drive inputs, advance one clock, update the model, check on the falling edge.
    task automatic step(input string tag, input logic l, input logic [W-1:0] p);
        load     = l;
        parallel = p;
        @(posedge clk);
        if (!rst) begin
            exp_m.delete();
            exp_l.delete();
        end else if (l) begin
            model_load(p);
        end else begin
            if (exp_m.size() != 0) void'(exp_m.pop_front());
            if (exp_l.size() != 0) void'(exp_l.pop_front());
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, W'($urandom_range(0, (1 << W) - 1)));
    endtask

    initial begin
        // Reset held with load active: everything stays low.
        rst = 1'b0;
        @(negedge clk);
        check_outputs("rst0");
        step("rst_load", 1'b1, 4'hF);
        step("rst_load", 1'b1, 4'hF);
        rst = 1'b1;

        step("basic", 1'b1, 4'b1101);
        idle("basic", W + 6);

        step("reload", 1'b1, 4'b1001);
        step("reload", 1'b0, 4'b0000);
        step("reload", 1'b1, 4'b0110);
        idle("reload", W + 5);

        step("held", 1'b1, 4'b1000);
        step("held", 1'b1, 4'b1000);
        step("held", 1'b1, 4'b1000);
        idle("held", W + 5);

        // Asynchronous reset mid-frame, asserted away from any clock edge.
        step("abort", 1'b1, 4'b1111);
        step("abort", 1'b0, 4'b0000);
        #2 rst = 1'b0;
        #1;
        exp_m.delete();
        exp_l.delete();
        check_outputs("abort_async");
        @(negedge clk);
        check_outputs("abort_held");
        rst = 1'b1;
        idle("abort_after", W + 3);

        // Random traffic: sparse loads, occasional back-to-back and held loads.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 25), W'($urandom_range(0, (1 << W) - 1)));
        end
        idle("rand_tail", W + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
